// File: rtl/drc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : drc_frame_ctrl
// Brief   : Frame capture controller. It locks onto SOF, counts pixels, tags the
//           last pixel and zero-pads truncated frames.
// Revision: 1.0 - initial release
// ============================================================================
module drc_frame_ctrl #(
    parameter int I_PXL_W   = 16,
    parameter int PXL_CNT_W = 20,
    parameter int FRM_CNT_W = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic                 cfg_cont,
    input  logic [PXL_CNT_W-1:0] cfg_pxl_num,
    input  logic [I_PXL_W-1:0]   i_pxl_dat,
    input  logic                 i_pxl_sof,
    input  logic                 i_pxl_vld,
    output logic                 i_pxl_rdy,
    output logic [I_PXL_W-1:0]   o_pxl_dat,
    output logic                 o_pxl_last,
    output logic                 o_pxl_vld,
    input  logic                 o_pxl_rdy,
    output logic                 sts_busy,
    output logic                 sts_frm_done,
    output logic [FRM_CNT_W-1:0] sts_frm_cnt,
    output logic                 sts_err_short
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_SOF = 2'd1;
    localparam logic [1:0] S_CAPTURE  = 2'd2;
    localparam logic [1:0] S_PAD      = 2'd3;

    localparam logic [PXL_CNT_W-1:0] c_PXL_ONE = {{(PXL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [FRM_CNT_W-1:0] c_FRM_ONE = {{(FRM_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic                 r_cont;
    logic                 r_stop_pend;
    logic [PXL_CNT_W-1:0] r_num;
    logic [PXL_CNT_W-1:0] r_cnt;
    logic [I_PXL_W-1:0]   r_out_dat;
    logic                 r_out_last;
    logic                 r_out_vld;
    logic [FRM_CNT_W-1:0] r_frm_cnt;
    logic                 r_err_short;

    logic                 w_ld;
    logic [PXL_CNT_W-1:0] w_num_in;
    logic                 w_cnt_at_end;
    logic                 w_in_rdy;
    logic                 w_load;
    logic [I_PXL_W-1:0]   w_load_dat;
    logic                 w_load_last;
    logic                 w_sof_acc;
    logic                 w_set_err;
    logic                 w_frame_end;
    logic [1:0]           w_end_state;
    logic                 w_done_hs;

    assign w_ld         = ~r_out_vld | o_pxl_rdy;
    assign w_num_in     = (cfg_pxl_num == '0) ? c_PXL_ONE : cfg_pxl_num;
    assign w_cnt_at_end = (r_cnt == (r_num - c_PXL_ONE));
    assign w_frame_end  = w_load & w_load_last;
    assign w_done_hs    = r_out_vld & r_out_last & o_pxl_rdy;
    // A stop arriving on the very cycle the last pixel is loaded still ends capture.
    assign w_end_state  = (~r_cont | r_stop_pend | cfg_stop) ? S_IDLE : S_WAIT_SOF;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) w_state_nxt = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (cfg_stop)         w_state_nxt = S_IDLE;
                else if (w_frame_end) w_state_nxt = w_end_state;
                else if (w_sof_acc)   w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_set_err)        w_state_nxt = S_PAD;
                else if (w_frame_end) w_state_nxt = w_end_state;
            end
            default: begin
                if (w_frame_end) w_state_nxt = w_end_state;
            end
        endcase
    end

    always_comb begin
        w_in_rdy    = 1'b1;
        w_load      = 1'b0;
        w_load_dat  = '0;
        w_load_last = 1'b0;
        w_sof_acc   = 1'b0;
        w_set_err   = 1'b0;
        case (r_state)
            S_WAIT_SOF: begin
                if (i_pxl_sof && !cfg_stop) begin
                    w_in_rdy = w_ld;
                    if (i_pxl_vld && w_ld) begin
                        w_load      = 1'b1;
                        w_sof_acc   = 1'b1;
                        w_load_dat  = i_pxl_dat;
                        w_load_last = (w_num_in == c_PXL_ONE);
                    end
                end
            end
            S_CAPTURE: begin
                // An SOF here means the sensor frame was short: hold it for WAIT_SOF.
                if (i_pxl_vld && i_pxl_sof) begin
                    w_in_rdy  = 1'b0;
                    w_set_err = 1'b1;
                end else begin
                    w_in_rdy = w_ld;
                    if (i_pxl_vld && w_ld) begin
                        w_load      = 1'b1;
                        w_load_dat  = i_pxl_dat;
                        w_load_last = w_cnt_at_end;
                    end
                end
            end
            S_PAD: begin
                w_in_rdy = 1'b0;
                if (w_ld) begin
                    w_load      = 1'b1;
                    w_load_last = w_cnt_at_end;
                end
            end
            default: begin
                w_in_rdy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cont      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_num       <= '0;
            r_cnt       <= '0;
            r_out_dat   <= '0;
            r_out_last  <= 1'b0;
            r_out_vld   <= 1'b0;
            r_frm_cnt   <= '0;
            r_err_short <= 1'b0;
        end else begin
            if (w_ld) begin
                r_out_vld  <= w_load;
                r_out_dat  <= w_load_dat;
                r_out_last <= w_load_last;
            end
            if (r_state == S_IDLE && cfg_start) begin
                r_cont      <= cfg_cont;
                r_err_short <= 1'b0;
            end else if (w_set_err) begin
                r_err_short <= 1'b1;
            end
            if (w_sof_acc) r_num <= w_num_in;
            if (w_frame_end)    r_cnt <= '0;
            else if (w_sof_acc) r_cnt <= c_PXL_ONE;
            else if (w_load)    r_cnt <= r_cnt + c_PXL_ONE;
            if (w_state_nxt == S_IDLE)
                r_stop_pend <= 1'b0;
            else if (cfg_stop && (r_state == S_CAPTURE || r_state == S_PAD))
                r_stop_pend <= 1'b1;
            if (w_done_hs) r_frm_cnt <= r_frm_cnt + c_FRM_ONE;
        end
    end

    assign i_pxl_rdy     = w_in_rdy;
    assign o_pxl_dat     = r_out_dat;
    assign o_pxl_last    = r_out_last;
    assign o_pxl_vld     = r_out_vld;
    assign sts_busy      = (r_state != S_IDLE);
    assign sts_frm_done  = w_done_hs;
    assign sts_frm_cnt   = r_frm_cnt;
    assign sts_err_short = r_err_short;

endmodule
`default_nettype wire

// File: tb/tb_drc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_drc_frame_ctrl
// Brief   : Scenario bench for drc_frame_ctrl against a frame-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_drc_frame_ctrl;

    localparam int c_PXL_W = 16;
    localparam int c_CNT_W = 20;
    // Narrow frame counter so the wrap scenario stays short.
    localparam int c_FRM_W = 8;

    logic                aclk      = 1'b0;
    logic                aresetn   = 1'b0;
    logic                cfg_start = 1'b0;
    logic                cfg_stop  = 1'b0;
    logic                cfg_cont  = 1'b0;
    logic [c_CNT_W-1:0]  cfg_pxl_num = '0;
    logic [c_PXL_W-1:0]  i_pxl_dat = '0;
    logic                i_pxl_sof = 1'b0;
    logic                i_pxl_vld = 1'b0;
    logic                i_pxl_rdy;
    logic [c_PXL_W-1:0]  o_pxl_dat;
    logic                o_pxl_last;
    logic                o_pxl_vld;
    logic                o_pxl_rdy = 1'b1;
    logic                sts_busy;
    logic                sts_frm_done;
    logic [c_FRM_W-1:0]  sts_frm_cnt;
    logic                sts_err_short;

    drc_frame_ctrl #(
        .I_PXL_W   (c_PXL_W),
        .PXL_CNT_W (c_CNT_W),
        .FRM_CNT_W (c_FRM_W)
    ) u_dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_start     (cfg_start),
        .cfg_stop      (cfg_stop),
        .cfg_cont      (cfg_cont),
        .cfg_pxl_num   (cfg_pxl_num),
        .i_pxl_dat     (i_pxl_dat),
        .i_pxl_sof     (i_pxl_sof),
        .i_pxl_vld     (i_pxl_vld),
        .i_pxl_rdy     (i_pxl_rdy),
        .o_pxl_dat     (o_pxl_dat),
        .o_pxl_last    (o_pxl_last),
        .o_pxl_vld     (o_pxl_vld),
        .o_pxl_rdy     (o_pxl_rdy),
        .sts_busy      (sts_busy),
        .sts_frm_done  (sts_frm_done),
        .sts_frm_cnt   (sts_frm_cnt),
        .sts_err_short (sts_err_short)
    );

    initial forever #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    logic               in_sof[$];
    logic [c_PXL_W-1:0] in_dat[$];
    logic [c_PXL_W-1:0] exp_dat[$];
    logic               exp_last[$];
    int                 exp_frames;
    logic               exp_short;
    logic [c_FRM_W-1:0] exp_frm = '0;

    logic [c_PXL_W-1:0] got_dat[$];
    logic               got_last[$];
    int                 done_cnt   = 0;
    int                 stall_viol = 0;
    logic               prev_stall = 1'b0;
    logic [c_PXL_W-1:0] prev_dat   = '0;
    logic               prev_last  = 1'b0;

    int rdy_mode = 0;  // 0: always ready, 1: toggling, 2: random

    initial forever begin
        @(posedge aclk); #1;
        case (rdy_mode)
            0:       o_pxl_rdy = 1'b1;
            1:       o_pxl_rdy = ~o_pxl_rdy;
            default: o_pxl_rdy = ($urandom_range(99) < 60);
        endcase
    end

    always @(negedge aclk) begin
        if (aresetn) begin
            if (prev_stall && (!o_pxl_vld || o_pxl_dat !== prev_dat || o_pxl_last !== prev_last))
                stall_viol++;
            if (o_pxl_vld && o_pxl_rdy) begin
                got_dat.push_back(o_pxl_dat);
                got_last.push_back(o_pxl_last);
            end
            if (sts_frm_done) done_cnt++;
            prev_stall = o_pxl_vld && !o_pxl_rdy;
            prev_dat   = o_pxl_dat;
            prev_last  = o_pxl_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame-level model: each accepted SOF opens a frame of N pixels; a new SOF
    // before N pixels ends it with zero padding; stray pixels between frames vanish.
    function automatic void build_model(input bit cont, input logic [c_CNT_W-1:0] num);
        int i;
        int nn;
        nn = (num == '0) ? 1 : int'(num);
        i  = 0;
        exp_dat.delete();
        exp_last.delete();
        exp_frames = 0;
        exp_short  = 1'b0;
        while (i < in_sof.size() && !in_sof[i]) i++;
        while (i < in_sof.size()) begin
            for (int k = 0; k < nn; k++) begin
                if (i >= in_sof.size()) break;
                if (k > 0 && in_sof[i]) begin
                    exp_short = 1'b1;
                    exp_dat.push_back('0);
                end else begin
                    exp_dat.push_back(in_dat[i]);
                    i++;
                end
                exp_last.push_back(k == nn - 1);
            end
            exp_frames++;
            if (!cont) break;
            while (i < in_sof.size() && !in_sof[i]) i++;
        end
    endfunction

    function automatic void push_pix(input logic sof, input logic [c_PXL_W-1:0] dat);
        in_sof.push_back(sof);
        in_dat.push_back(dat);
    endfunction

    function automatic void gen_stream(input int frames, input int nn, input int max_extra);
        int len;
        in_sof.delete();
        in_dat.delete();
        repeat ($urandom_range(2)) push_pix(1'b0, c_PXL_W'($urandom));
        for (int f = 0; f < frames; f++) begin
            if (f == frames - 1) len = nn + int'($urandom_range(max_extra));
            else                 len = int'($urandom_range(nn + max_extra, 1));
            push_pix(1'b1, c_PXL_W'($urandom));
            for (int j = 1; j < len; j++) push_pix(1'b0, c_PXL_W'($urandom));
        end
    endfunction

    // Arms the DUT, feeds in_* with random valid gaps, drains and scores the run.
    task automatic run_stream(input string name, input bit cont, input logic [c_CNT_W-1:0] num,
                              input int stop_idx, input int gap_pct);
        int idx, cyc, g0, d0, v0, ngot;
        bit stopped;
        build_model(cont && (stop_idx < 0), num);
        g0 = got_dat.size();
        d0 = done_cnt;
        v0 = stall_viol;
        cfg_cont    = cont;
        cfg_pxl_num = num;
        cfg_start   = 1'b1;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
        total++;
        if (sts_busy !== 1'b1) begin
            bad++;
            $display("FAIL %s.busy_on_start: got %b expected 1", name, sts_busy);
        end
        idx = 0;
        cyc = 0;
        stopped = 1'b0;
        while (idx < in_sof.size() && cyc < 20000) begin
            cfg_stop = (idx == stop_idx) && !stopped;
            if (cfg_stop) stopped = 1'b1;
            if ($urandom_range(99) < gap_pct) begin
                i_pxl_vld = 1'b0;
            end else begin
                i_pxl_vld = 1'b1;
                i_pxl_sof = in_sof[idx];
                i_pxl_dat = in_dat[idx];
            end
            @(negedge aclk);
            if (i_pxl_vld && i_pxl_rdy) idx++;
            @(posedge aclk); #1;
            cyc++;
        end
        i_pxl_vld = 1'b0;
        i_pxl_sof = 1'b0;
        cfg_stop  = 1'b0;
        total++;
        if (idx != in_sof.size()) begin
            bad++;
            $display("FAIL %s.input_accept: got %0d pixels taken expected %0d", name, idx, in_sof.size());
        end
        cyc = 0;
        while ((got_dat.size() - g0) < exp_dat.size() && cyc < 1000) begin
            @(posedge aclk); #1;
            cyc++;
        end
        repeat (4) begin
            @(posedge aclk); #1;
        end
        ngot = got_dat.size() - g0;
        total++;
        if (ngot != exp_dat.size()) begin
            bad++;
            $display("FAIL %s.out_count: got %0d expected %0d", name, ngot, exp_dat.size());
        end
        for (int j = 0; j < exp_dat.size() && j < ngot; j++) begin
            total++;
            if (got_dat[g0+j] !== exp_dat[j] || got_last[g0+j] !== exp_last[j]) begin
                bad++;
                $display("FAIL %s.pixel[%0d]: got dat=%h last=%b expected dat=%h last=%b",
                         name, j, got_dat[g0+j], got_last[g0+j], exp_dat[j], exp_last[j]);
            end
        end
        exp_frm = exp_frm + c_FRM_W'(exp_frames);
        total++;
        if (sts_frm_cnt !== exp_frm) begin
            bad++;
            $display("FAIL %s.frm_cnt: got %0d expected %0d", name, sts_frm_cnt, exp_frm);
        end
        total++;
        if ((done_cnt - d0) != exp_frames) begin
            bad++;
            $display("FAIL %s.frm_done_pulses: got %0d expected %0d", name, done_cnt - d0, exp_frames);
        end
        total++;
        if (sts_err_short !== exp_short) begin
            bad++;
            $display("FAIL %s.err_short: got %b expected %b", name, sts_err_short, exp_short);
        end
        total++;
        if (stall_viol != v0) begin
            bad++;
            $display("FAIL %s.stall_stable: got %0d violations expected 0", name, stall_viol - v0);
        end
        if (cont && stop_idx < 0) begin
            total++;
            if (sts_busy !== 1'b1) begin
                bad++;
                $display("FAIL %s.busy_wait_sof: got %b expected 1", name, sts_busy);
            end
            cfg_stop = 1'b1;
            @(posedge aclk); #1;
            cfg_stop = 1'b0;
            total++;
            if (sts_busy !== 1'b0) begin
                bad++;
                $display("FAIL %s.stop_in_wait_sof: got busy=%b expected 0", name, sts_busy);
            end
        end else begin
            total++;
            if (sts_busy !== 1'b0) begin
                bad++;
                $display("FAIL %s.idle_at_end: got busy=%b expected 0", name, sts_busy);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        total++;
        if (o_pxl_vld !== 1'b0 || o_pxl_last !== 1'b0 || o_pxl_dat !== '0) begin
            bad++;
            $display("FAIL reset.out: got vld=%b last=%b dat=%h expected 0 0 0", o_pxl_vld, o_pxl_last, o_pxl_dat);
        end
        total++;
        if (sts_busy !== 1'b0 || sts_frm_done !== 1'b0 || sts_frm_cnt !== '0 || sts_err_short !== 1'b0) begin
            bad++;
            $display("FAIL reset.sts: got busy=%b done=%b cnt=%0d err=%b expected all 0",
                     sts_busy, sts_frm_done, sts_frm_cnt, sts_err_short);
        end
        aresetn = 1'b1;
        repeat (2) begin
            @(posedge aclk); #1;
        end
        total++;
        if (i_pxl_rdy !== 1'b1 || sts_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset.idle_rdy: got rdy=%b busy=%b expected 1 0", i_pxl_rdy, sts_busy);
        end
    endtask

    task automatic test_single();
        rdy_mode = 0;
        in_sof.delete();
        in_dat.delete();
        for (int p = 1; p <= 8; p++) push_pix(p == 1, c_PXL_W'(p));
        run_stream("single", 1'b0, 20'd4, -1, 0);
    endtask

    task automatic test_cont_backpressure();
        rdy_mode = 1;
        in_sof.delete();
        in_dat.delete();
        push_pix(1'b1, 16'h00A1); push_pix(1'b0, 16'h00A2); push_pix(1'b0, 16'h00A3);
        push_pix(1'b1, 16'h00B1); push_pix(1'b0, 16'h00B2); push_pix(1'b0, 16'h00B3);
        run_stream("cont_bp", 1'b1, 20'd3, -1, 0);
        rdy_mode = 0;
    endtask

    task automatic test_short_frame();
        rdy_mode = 0;
        in_sof.delete();
        in_dat.delete();
        push_pix(1'b1, 16'h0010); push_pix(1'b0, 16'h0011); push_pix(1'b0, 16'h0012);
        push_pix(1'b1, 16'h0020);
        for (int p = 1; p <= 4; p++) push_pix(1'b0, c_PXL_W'(16'h0020 + p));
        run_stream("short", 1'b1, 20'd5, -1, 0);
    endtask

    task automatic test_stop();
        rdy_mode = 0;
        in_sof.delete();
        in_dat.delete();
        for (int p = 1; p <= 8; p++) push_pix(p == 1 || p == 5, c_PXL_W'(p));
        run_stream("stop", 1'b1, 20'd4, 2, 0);
    endtask

    task automatic test_pxl_num_zero();
        rdy_mode = 2;
        in_sof.delete();
        in_dat.delete();
        push_pix(1'b1, 16'h0101); push_pix(1'b0, 16'h0102);
        push_pix(1'b1, 16'h0201); push_pix(1'b1, 16'h0301);
        push_pix(1'b0, 16'h0302); push_pix(1'b0, 16'h0303); push_pix(1'b1, 16'h0401);
        run_stream("num_zero", 1'b1, 20'd0, -1, 20);
        rdy_mode = 0;
    endtask

    task automatic test_random(input int iters);
        bit cont;
        int num;
        rdy_mode = 2;
        for (int it = 0; it < iters; it++) begin
            cont = 1'(($urandom_range(1)));
            num  = int'($urandom_range(6));
            gen_stream(int'($urandom_range(4, 1)), (num == 0) ? 1 : num, 3);
            run_stream("random", cont, c_CNT_W'(num), -1, 30);
        end
        rdy_mode = 0;
    endtask

    task automatic test_frm_cnt_wrap();
        int k;
        rdy_mode = 0;
        k = 255 - int'(exp_frm);
        if (k == 0) k = 256;
        in_sof.delete();
        in_dat.delete();
        for (int p = 0; p < k; p++) push_pix(1'b1, c_PXL_W'($urandom));
        run_stream("wrap_fill", 1'b1, 20'd0, -1, 0);
        total++;
        if (sts_frm_cnt !== 8'hFF) begin
            bad++;
            $display("FAIL wrap.at_max: got %h expected ff", sts_frm_cnt);
        end
        in_sof.delete();
        in_dat.delete();
        push_pix(1'b1, 16'hBEEF);
        run_stream("wrap_over", 1'b1, 20'd0, -1, 0);
        total++;
        if (sts_frm_cnt !== 8'h00) begin
            bad++;
            $display("FAIL wrap.rollover: got %h expected 00", sts_frm_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        rdy_mode    = 0;
        cfg_cont    = 1'b1;
        cfg_pxl_num = 20'd8;
        cfg_start   = 1'b1;
        @(posedge aclk); #1;
        cfg_start = 1'b0;
        i_pxl_vld = 1'b1; i_pxl_sof = 1'b1; i_pxl_dat = 16'h0011;
        @(posedge aclk); #1;
        i_pxl_sof = 1'b0; i_pxl_dat = 16'h0022;
        @(posedge aclk); #1;
        i_pxl_sof = 1'b1; i_pxl_dat = 16'h0033;
        repeat (2) begin
            @(posedge aclk); #1;
        end
        total++;
        if (sts_busy !== 1'b1 || sts_err_short !== 1'b1 || o_pxl_vld !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid.pre: got busy=%b err=%b vld=%b expected 1 1 1",
                     sts_busy, sts_err_short, o_pxl_vld);
        end
        #2;
        aresetn = 1'b0;
        #1;
        total++;
        if (o_pxl_vld !== 1'b0 || o_pxl_last !== 1'b0 || o_pxl_dat !== '0) begin
            bad++;
            $display("FAIL reset_mid.out: got vld=%b last=%b dat=%h expected 0 0 0", o_pxl_vld, o_pxl_last, o_pxl_dat);
        end
        total++;
        if (sts_busy !== 1'b0 || sts_frm_done !== 1'b0 || sts_frm_cnt !== '0 || sts_err_short !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid.sts: got busy=%b done=%b cnt=%0d err=%b expected all 0",
                     sts_busy, sts_frm_done, sts_frm_cnt, sts_err_short);
        end
        i_pxl_vld = 1'b0;
        i_pxl_sof = 1'b0;
        exp_frm   = '0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) begin
            @(posedge aclk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_cont_backpressure();
        test_short_frame();
        test_stop();
        test_pxl_num_zero();
        test_random(6);
        test_frm_cnt_wrap();
        test_reset_mid_frame();
        test_random(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
